// File: rtl/segrun_pkg.sv
// Shared types and constants for the runner game-logic stage.
// Lane geometry, score range, FSM encoding and obstacle LFSR.
package segrun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int LANE_W  = 6;
    localparam int SCORE_W = 14;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic LANE_FLOOR = 1'b0;
    localparam logic LANE_CEIL  = 1'b1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/runner_tick_gen.sv
// Game tick divider: one-cycle pulse every TICK_DIV enabled cycles.
// The count restarts from zero whenever enable drops.
module runner_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/runner_engine.sv
// Runner game logic: scrolling obstacle lanes, player lane, collisions
// and score, feeding the seven-segment decoder.
module runner_engine #(
    parameter int                  TICK_DIV  = 25000000,
    parameter logic [7:0]          LFSR_SEED = 8'hA5,
    parameter logic [13:0]         SCORE_MAX = segrun_pkg::SCORE_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          loggedIn,
    input  logic                          flip,
    output logic [segrun_pkg::LANE_W-1:0] ceilingBits,
    output logic [segrun_pkg::LANE_W-1:0] floorBits,
    output logic                          playerPos,
    output logic [segrun_pkg::SCORE_W-1:0] score,
    output logic                          showScore,
    output logic                          gameOver
);

    import segrun_pkg::*;

    state_t state;

    logic [2:0] fsync;
    logic       flip_edge;
    logic       playing;
    logic       tick;
    logic [7:0] lfsr;
    logic [7:0] lfsr_adv;

    logic [LANE_W-1:0]  ceil_sh;
    logic [LANE_W-1:0]  floor_sh;
    logic               new_pos;
    logic               hit_flip;
    logic               hit_tick;
    logic [SCORE_W-1:0] score_inc;

    assign flip_edge = fsync[1] & ~fsync[2];
    assign playing   = (state == PLAY);

    runner_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(playing),
        .tick  (tick)
    );

    always_comb begin
        lfsr_adv = lfsr_next(lfsr);
        ceil_sh  = {1'b0, ceilingBits[LANE_W-1:1]};
        floor_sh = {1'b0, floorBits[LANE_W-1:1]};
        // Entry column stays empty next to any obstacle: keeps a gap
        if (!(ceil_sh[LANE_W-2] | floor_sh[LANE_W-2])) begin
            ceil_sh[LANE_W-1]  = (lfsr_adv[1:0] == 2'b00);
            floor_sh[LANE_W-1] = (lfsr_adv[1:0] == 2'b01);
        end
        new_pos  = flip_edge ? ~playerPos : playerPos;
        hit_flip = flip_edge &
                   ((new_pos == LANE_CEIL) ? ceilingBits[0] : floorBits[0]);
        hit_tick = (new_pos == LANE_CEIL) ? ceil_sh[0] : floor_sh[0];
        score_inc = (score >= SCORE_MAX) ? SCORE_MAX : score + 14'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fsync       <= '0;
            lfsr        <= LFSR_SEED;
            ceilingBits <= '0;
            floorBits   <= '0;
            playerPos   <= LANE_FLOOR;
            score       <= '0;
            showScore   <= 1'b0;
            gameOver    <= 1'b0;
        end else begin
            fsync    <= {fsync[1:0], flip};
            gameOver <= 1'b0;
            if (!loggedIn) begin
                state       <= IDLE;
                ceilingBits <= '0;
                floorBits   <= '0;
                playerPos   <= LANE_FLOOR;
                score       <= '0;
                showScore   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (flip_edge) state <= PLAY;
                    end
                    PLAY: begin
                        if (tick) lfsr <= lfsr_adv;
                        if (flip_edge) playerPos <= new_pos;
                        // A flip into an obstacle ends the game before the scroll
                        if (hit_flip) begin
                            state     <= OVER;
                            showScore <= 1'b1;
                            gameOver  <= 1'b1;
                        end else if (tick) begin
                            ceilingBits <= ceil_sh;
                            floorBits   <= floor_sh;
                            if (hit_tick) begin
                                state     <= OVER;
                                showScore <= 1'b1;
                                gameOver  <= 1'b1;
                            end else begin
                                score <= score_inc;
                            end
                        end
                    end
                    OVER: begin
                        if (flip_edge) begin
                            state       <= IDLE;
                            ceilingBits <= '0;
                            floorBits   <= '0;
                            playerPos   <= LANE_FLOOR;
                            score       <= '0;
                            showScore   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_runner_engine.sv
// Directed bench for runner_engine with a per-tick reference model.
// Small TICK_DIV and SCORE_MAX keep games short.
module tb_runner_engine;

    localparam int          TDIV = 4;
    localparam logic [13:0] SMAX = 14'd22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loggedIn;
    logic        flip;
    logic [5:0]  ceilingBits;
    logic [5:0]  floorBits;
    logic        playerPos;
    logic [13:0] score;
    logic        showScore;
    logic        gameOver;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  m_lfsr;
    logic [5:0]  m_ceil;
    logic [5:0]  m_floor;
    logic        m_pos;
    logic [13:0] m_score;
    logic        m_over;

    runner_engine #(
        .TICK_DIV (TDIV),
        .LFSR_SEED(8'hA5),
        .SCORE_MAX(SMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loggedIn   (loggedIn),
        .flip       (flip),
        .ceilingBits(ceilingBits),
        .floorBits  (floorBits),
        .playerPos  (playerPos),
        .score      (score),
        .showScore  (showScore),
        .gameOver   (gameOver)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flip();
        flip = 1'b1;
        step(1);
        flip = 1'b0;
    endtask

    task automatic m_clear();
        m_ceil  = '0;
        m_floor = '0;
        m_pos   = 1'b0;
        m_score = '0;
        m_over  = 1'b0;
    endtask

    task automatic m_flip();
        m_pos = ~m_pos;
        if (m_pos ? m_ceil[0] : m_floor[0]) m_over = 1'b1;
    endtask

    task automatic m_tick();
        logic       fb;
        logic [5:0] c;
        logic [5:0] f;
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
        c = m_ceil >> 1;
        f = m_floor >> 1;
        if (!c[4] && !f[4]) begin
            if (m_lfsr[1:0] == 2'b00) c[5] = 1'b1;
            if (m_lfsr[1:0] == 2'b01) f[5] = 1'b1;
        end
        m_ceil  = c;
        m_floor = f;
        if (m_pos ? c[0] : f[0]) m_over = 1'b1;
        else if (m_score < SMAX) m_score = m_score + 14'd1;
    endtask

    task automatic cmp(input string tag, input logic exp_go);
        logic [5:0] occ;
        occ = ceilingBits | floorBits;
        check({tag, ".ceil"}, 32'(ceilingBits), 32'(m_ceil));
        check({tag, ".floor"}, 32'(floorBits), 32'(m_floor));
        check({tag, ".pos"}, 32'(playerPos), 32'(m_pos));
        check({tag, ".score"}, 32'(score), 32'(m_score));
        check({tag, ".show"}, 32'(showScore), 32'(m_over));
        check({tag, ".gover"}, 32'(gameOver), 32'(exp_go));
        check({tag, ".both"}, 32'(ceilingBits & floorBits), 32'd0);
        check({tag, ".adj"}, 32'(occ & (occ >> 1)), 32'd0);
    endtask

    // mode 0: no flip; 1: flip lands one cycle before the tick;
    // 2: flip lands on the tick edge itself
    task automatic run_tick(input string tag, input int mode);
        if (mode == 1) begin
            pulse_flip();
            step(2);
            m_flip();
            check({tag, ".preflip_pos"}, 32'(playerPos), 32'(m_pos));
            check({tag, ".preflip_show"}, 32'(showScore), 32'(m_over));
            step(1);
        end else if (mode == 2) begin
            step(1);
            pulse_flip();
            step(2);
            m_flip();
        end else begin
            step(TDIV);
        end
        if (!m_over) m_tick();
        cmp(tag, m_over);
    endtask

    function automatic int dodge();
        logic [5:0] mine;
        mine = m_pos ? m_ceil : m_floor;
        return mine[1] ? 1 : 0;
    endfunction

    task automatic enter_play();
        pulse_flip();
        step(2);
    endtask

    task automatic after_over(input string tag);
        step(1);
        cmp({tag, ".over1"}, 1'b0);
        step(8);
        cmp({tag, ".frozen"}, 1'b0);
        pulse_flip();
        step(2);
        m_clear();
        cmp({tag, ".idle"}, 1'b0);
    endtask

    initial begin
        logic any;
        int   mode;
        rst_n    = 1'b0;
        loggedIn = 1'b0;
        flip     = 1'b0;
        m_lfsr   = 8'hA5;
        m_clear();
        step(2);
        cmp("reset", 1'b0);
        rst_n = 1'b1;
        step(1);

        // Logged in but no flip: stays idle, no ticks
        loggedIn = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            any |= |{ceilingBits, floorBits, playerPos, score,
                     showScore, gameOver};
        end
        check("idle_quiet", 32'(any), 32'd0);

        // Game 1: first tick exactly TDIV cycles after entry
        enter_play();
        step(TDIV - 1);
        check("pretick.score", 32'(score), 32'd0);
        check("pretick.lanes", 32'({ceilingBits, floorBits}), 32'd0);
        step(1);
        m_tick();
        cmp("tick1", 1'b0);
        check("tick1.score", 32'(score), 32'd1);
        for (int i = 2; i <= 20; i++) run_tick("g1", dodge());
        check("score20", 32'(score), 32'd20);
        for (int i = 21; i <= 24; i++) run_tick("g1sat", dodge());
        check("score_sat", 32'(score), 32'(SMAX));

        // Steer into the floor lane and let a floor obstacle hit
        for (int i = 0; i < 300 && !m_over; i++) begin
            mode = (m_pos && !m_floor[0]) ? 1 : 0;
            run_tick("g1hunt", mode);
        end
        check("g1.over", 32'(showScore), 32'd1);
        check("g1.floorhit", 32'(floorBits[0] & ~playerPos), 32'd1);
        check("g1.score_kept", 32'(score), 32'(SMAX));
        after_over("g1");

        // Games 2 and 3: ceiling obstacle reaching column 0 while on floor
        for (int g = 2; g <= 3; g++) begin
            enter_play();
            for (int i = 0; i < 300 && !m_over; i++) begin
                if (!m_pos && m_ceil[1]) mode = (g == 2) ? 2 : 1;
                else if (m_pos && m_ceil[1]) mode = 1;
                else if (m_pos && !m_floor[0] && !m_floor[1]) mode = 1;
                else if (!m_pos && m_floor[1]) mode = 1;
                else mode = 0;
                run_tick((g == 2) ? "g2" : "g3", mode);
            end
            check((g == 2) ? "g2.over" : "g3.over", 32'(showScore), 32'd1);
            check((g == 2) ? "g2.ceilhit" : "g3.ceilhit",
                  32'(ceilingBits[0] & playerPos), 32'd1);
            after_over((g == 2) ? "g2" : "g3");
        end

        // Game 4: logout mid-play clears everything next cycle
        enter_play();
        run_tick("g4", dodge());
        run_tick("g4", dodge());
        check("g4.score2", 32'(score), 32'd2);
        loggedIn = 1'b0;
        step(1);
        m_clear();
        cmp("logout", 1'b0);
        loggedIn = 1'b1;
        step(1);

        // Game 5: asynchronous reset mid-tick, then reseeded LFSR
        enter_play();
        run_tick("g5", dodge());
        run_tick("g5", dodge());
        step(2);
        rst_n = 1'b0;
        #1;
        m_lfsr = 8'hA5;
        m_clear();
        cmp("async_rst", 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        enter_play();
        for (int i = 0; i < 4; i++) run_tick("reseed", dodge());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/runner_engine.md
Name: runner_engine

Overview:
- Game-logic stage directly upstream of the seven-segment Decoder.
- Scrolls ceiling/floor obstacle lanes one column per game tick and tracks the player lane.
- Detects collisions and counts score.
- Drives the Decoder's ceilingBits, floorBits, playerPos, score and showScore inputs; loggedIn passes through to both blocks.

Parameters:
TICK_DIV, 25000000, clk cycles per game tick (0.5 s at 50 MHz); benches use 4
LFSR_SEED, 8'hA5, nonzero reset value of the obstacle LFSR
SCORE_MAX, 9999, score saturation value (14'b10011100001111)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
loggedIn  in  1  session active; low forces IDLE
flip  in  1  raw player button, asynchronous level, active high
ceilingBits  out  6  ceiling obstacles; bit5 = entry column, bit0 = player column
floorBits  out  6  floor obstacles, same column map
playerPos  out  1  0 = floor lane, 1 = ceiling lane
score  out  14  binary score, 0..SCORE_MAX
showScore  out  1  high in OVER
gameOver  out  1  one-cycle pulse on entry to OVER

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ceilingBits=0, floorBits=0, playerPos=0, score=0, showScore=0, gameOver=0; LFSR=LFSR_SEED; tick counter=0. All outputs are registered.
- Input conditioning: flip passes through a 2-FF synchroniser. flip_edge = synced rising edge, one cycle wide, 3 clk after the raw rise.
- Tick generator: counts 0..TICK_DIV-1 only in PLAY. tick pulses one cycle when the count wraps. The counter clears on any exit from PLAY.
- IDLE: outputs held at reset values.
  - loggedIn=1 and flip_edge -> PLAY. The first tick occurs TICK_DIV cycles later.
- PLAY, on flip_edge: playerPos toggles.
  - If the new lane's bit0 is set -> OVER. The toggle is still applied.
- PLAY, on tick: LFSR advances (x^8+x^6+x^5+x^4+1, Fibonacci, shift left). Both lanes shift right by one (bit5->bit4 ... bit0 dropped).
  - New bit5 comes from the advanced LFSR: lfsr[1:0]=00 -> ceiling, 01 -> floor, else empty.
  - New bit5 is forced empty if post-shift bit4 of either lane is 1, guaranteeing a gap of at least one column. Never both lanes in one column.
  - After shifting, if the current lane's bit0=1 -> OVER; score is not incremented and the shifted lanes remain visible.
  - Otherwise score = min(score+1, SCORE_MAX).
- Tick and flip_edge in the same cycle: apply the toggle first, then run the tick collision check against the new lane. At most one OVER entry results.
- OVER: lanes, playerPos and score frozen; showScore=1.
  - gameOver=1 on the first OVER cycle only.
  - flip_edge -> IDLE: all outputs cleared, LFSR NOT reseeded.
- loggedIn=0 in any state -> IDLE next cycle with outputs cleared. This takes priority over tick and flip.
- Score saturates and never wraps. The LFSR never reaches 0 (seed nonzero, maximal polynomial).

Decomposition:
- segrun_pkg holds:
  - state encoding IDLE=2'd0, PLAY=2'd1, OVER=2'd2
  - LANE_W=6, SCORE_W=14, SCORE_MAX=14'd9999
  - LFSR taps
  - LANE_FLOOR=1'b0, LANE_CEIL=1'b1
- One sub-module, runner_tick_gen: parameter TICK_DIV; inputs clk, rst_n, enable; output tick (one-cycle pulse; counter clears when enable is low).
- Synchroniser, LFSR and FSM stay in runner_engine.

Test Plan:
1. Reset, then loggedIn=1 with no flip for 50 cycles -> state IDLE, all outputs 0, no tick. Then pulse flip -> PLAY; first tick 4 clk later (TICK_DIV=4).
2. Seed 8'hA5, play with no flips for 20 ticks, no collision (force the LFSR floor-free via seed override) -> score=20 and bit-exact lane patterns vs. reference model. Never both lanes set in one column; never obstacles in adjacent columns.
3. Floor obstacle reaches bit0 with playerPos=0 -> OVER on that tick: floorBits[0]=1, score unchanged, showScore=1, gameOver high for exactly 1 cycle.
4. flip_edge in the same cycle as a tick that brings a ceiling obstacle to bit0 while playerPos=0 -> playerPos=1, OVER. Flip two cycles earlier instead -> collision at the tick.
5. Preload score to 9998, survive 3 ticks -> score 9999, 9999, 9999 (14'b10011100001111); no wrap.
6. In PLAY, deassert loggedIn -> next cycle IDLE, lanes=0, score=0. Assert rst_n=0 mid-tick -> outputs 0 immediately (asynchronous), LFSR=8'hA5 after release.
